br_flush_ctrl: RTL and testbench
================================

BR_FLUSH_CTRL -- requirements
Module: br_flush_ctrl

Interface
REQ-001 Parameter ROB_DEPTH, default 16: ROB entry count, power of two.
REQ-002 Parameter ROB_IDX_W, default 4: ROB index width, equal to log2(ROB_DEPTH).
REQ-003 Parameter RECOVER_CYCLES, default 2: post-flush stall cycles, legal range 1-15.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 br_valid  input  1  branch/jump result valid from branch execute unit this cycle.
REQ-007 br_en  input  1  resolved taken; predict-not-taken policy makes this the mispredict flag.
REQ-008 br_rob_idx  input  ROB_IDX_W  ROB index of resolved branch.
REQ-009 br_pc_new  input  32  redirect target of resolved branch.
REQ-010 rob_head_idx  input  ROB_IDX_W  current ROB head index.
REQ-011 rob_commit  input  1  ROB head entry commits this cycle.
REQ-012 flush  output  1  one-cycle pulse clearing ROB, reservation stations, rename state, and fetch queue.
REQ-013 redirect_valid  output  1  one-cycle pulse loading redirect_pc into fetch PC.
REQ-014 redirect_pc  output  32  redirect target; valid only while redirect_valid=1.
REQ-015 dispatch_stall  output  1  blocks fetch/dispatch during recovery.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 The block SHALL implement FSM states IDLE, PENDING, FLUSH, RECOVER, encoded in registers.
REQ-018 Age rule: entry A is older than entry B when (A - rob_head_idx) mod ROB_DEPTH < (B - rob_head_idx) mod ROB_DEPTH, computed in ROB_IDX_W-bit unsigned arithmetic with wrap-around.
REQ-019 IDLE: on br_valid=1 and br_en=1, capture br_rob_idx into pend_idx and br_pc_new into pend_pc, and go to PENDING next cycle; br_valid with br_en=0 is ignored.
REQ-020 IDLE SHALL NOT examine rob_commit; the commit match starts the cycle after capture.
REQ-021 PENDING with rob_commit=1 and rob_head_idx==pend_idx: go to FLUSH next cycle, ignoring any same-cycle br_valid.
REQ-022 PENDING without that commit match, on br_valid=1, br_en=1, and br_rob_idx older than pend_idx: replace pend_idx and pend_pc, and stay in PENDING.
REQ-023 PENDING with a younger or equal-index mispredict: no change to pend_idx or pend_pc.
REQ-024 FLUSH lasts exactly one cycle, during which flush=1, redirect_valid=1, redirect_pc=pend_pc, and dispatch_stall=1; next state is RECOVER with the counter loaded to RECOVER_CYCLES.
REQ-025 RECOVER holds dispatch_stall=1 and decrements the counter each cycle; on the cycle the counter reads 1, the next state is IDLE.
REQ-026 RECOVER therefore lasts exactly RECOVER_CYCLES cycles.
REQ-027 All br_valid and rob_commit inputs during FLUSH and RECOVER SHALL be ignored as wrong-path.
REQ-028 flush, redirect_valid, and dispatch_stall SHALL be driven from registered state only; no combinational path from any input.
REQ-029 redirect_pc SHALL be 0 whenever redirect_valid=0.
REQ-030 busy=1 in PENDING, FLUSH, and RECOVER; busy=0 in IDLE.
REQ-031 Total latency SHALL be: commit edge, then flush pulse in the next cycle, then RECOVER_CYCLES stall cycles, then IDLE.

Reset
REQ-032 rst=1 SHALL immediately force state=IDLE, pend_idx=0, pend_pc=0, and counter=0, independent of clk.
REQ-033 During reset, all outputs SHALL be 0: flush, redirect_valid, redirect_pc, dispatch_stall, and busy.
REQ-034 Reset asserted mid-PENDING, mid-FLUSH, or mid-RECOVER SHALL abandon the operation with no flush or redirect pulse after deassertion.
REQ-035 The first input capture SHALL occur on the first rising edge after rst deasserts.

Verification
REQ-036 Basic mispredict: head=3, br_valid=1, br_en=1, idx=5, pc_new=0x6000_0040; 4 cycles later rob_commit=1 with head=5 -> the next cycle shows a flush=1 and redirect_valid=1 pulse with redirect_pc=0x6000_0040, then dispatch_stall=1 for 2 cycles, then busy=0.
REQ-037 Older replace with wrap-around: head=14, pending idx=1, pc=0x100; new mispredict at idx=15, pc=0x200 -> pend replaced; commit at head=15 -> redirect_pc=0x200.
REQ-038 Younger ignored: head=0, pending idx=2, pc=0x100; mispredict at idx=7, pc=0x300 -> pend unchanged; commit at head=2 -> redirect_pc=0x100.
REQ-039 Not-taken and wrong-path: br_en=0 in IDLE -> no state change; a mispredict during RECOVER -> ignored, FSM returns to IDLE, busy=0.
REQ-040 Simultaneous events: in PENDING idx=4, same cycle rob_commit=1 at head=4 and br_valid=1, br_en=1, idx=4 -> exactly one flush pulse, with the original pend_pc.
REQ-041 Async reset: assert rst mid-RECOVER between clock edges -> outputs 0 before the next edge; after release, no flush pulse, and busy=0.

Source files
------------

// File: rtl/br_flush_ctrl.sv
// -----------------------------------------------------------------------------
// br_flush_ctrl
//   Branch-mispredict flush controller. It records the oldest outstanding taken
//   branch (predict-not-taken policy, so "taken" means mispredicted). When that
//   branch commits at the ROB head, it issues a one-cycle flush/redirect pulse.
//   It then stalls dispatch for RECOVER_CYCLES cycles before returning to idle.
//
// Ports
//   clk            : single clock, rising-edge active
//   rst            : asynchronous active-high reset
//   br_valid       : branch result valid from the branch execute unit
//   br_en          : branch resolved taken (mispredict flag)
//   br_rob_idx     : ROB index of the resolved branch
//   br_pc_new      : redirect target of the resolved branch
//   rob_head_idx   : current ROB head index
//   rob_commit     : ROB head entry commits this cycle
//   flush          : one-cycle pulse clearing ROB/RS/rename/fetch queue
//   redirect_valid : one-cycle pulse loading redirect_pc into the fetch PC
//   redirect_pc    : redirect target, zero whenever redirect_valid is low
//   dispatch_stall : blocks fetch/dispatch during flush and recovery
//   busy           : high in any state other than IDLE
// -----------------------------------------------------------------------------
module br_flush_ctrl #(
  parameter int ROB_DEPTH      = 16,
  parameter int ROB_IDX_W      = 4,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 br_valid,
  input  logic                 br_en,
  input  logic [ROB_IDX_W-1:0] br_rob_idx,
  input  logic [31:0]          br_pc_new,
  input  logic [ROB_IDX_W-1:0] rob_head_idx,
  input  logic                 rob_commit,
  output logic                 flush,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc,
  output logic                 dispatch_stall,
  output logic                 busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

  localparam logic [ROB_IDX_W-1:0] IDX_MASK = ROB_IDX_W'(ROB_DEPTH - 1);
  localparam logic [3:0]           CNT_LOAD = 4'(RECOVER_CYCLES);

  state_t               state_r, state_s;
  logic [ROB_IDX_W-1:0] pend_idx_r, pend_idx_s;
  logic [31:0]          pend_pc_r, pend_pc_s;
  logic [3:0]           cnt_r, cnt_s;

  // Age compare relative to the ROB head: distance from head wraps modulo
  // ROB_DEPTH, so a smaller distance means an older entry.
  function automatic logic is_older(input logic [ROB_IDX_W-1:0] a,
                                    input logic [ROB_IDX_W-1:0] b,
                                    input logic [ROB_IDX_W-1:0] head);
    logic [ROB_IDX_W-1:0] dist_a;
    logic [ROB_IDX_W-1:0] dist_b;
    dist_a = (a - head) & IDX_MASK;
    dist_b = (b - head) & IDX_MASK;
    return (dist_a < dist_b);
  endfunction

  // Next-state, pending-branch and recovery-counter logic.
  always_comb begin
    state_s    = state_r;
    pend_idx_s = pend_idx_r;
    pend_pc_s  = pend_pc_r;
    cnt_s      = cnt_r;
    case (state_r)
      ST_IDLE: begin
        // Commit is deliberately not looked at here: matching starts only
        // once the branch has been captured.
        if (br_valid && br_en) begin
          pend_idx_s = br_rob_idx;
          pend_pc_s  = br_pc_new;
          state_s    = ST_PENDING;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PENDING: begin
        // A commit of the pending branch wins over any same-cycle mispredict.
        if (rob_commit && (rob_head_idx == pend_idx_r)) begin
          state_s = ST_FLUSH;
        end else if (br_valid && br_en &&
                     is_older(br_rob_idx, pend_idx_r, rob_head_idx)) begin
          pend_idx_s = br_rob_idx;
          pend_pc_s  = br_pc_new;
          state_s    = ST_PENDING;
        end else begin
          state_s = ST_PENDING;
        end
      end
      ST_FLUSH: begin
        state_s = ST_RECOVER;
        cnt_s   = CNT_LOAD;
      end
      ST_RECOVER: begin
        // Everything arriving now is wrong-path and is dropped.
        if (cnt_r <= 4'd1) begin
          state_s = ST_IDLE;
          cnt_s   = 4'd0;
        end else begin
          state_s = ST_RECOVER;
          cnt_s   = cnt_r - 4'd1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // State, pending-branch and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      pend_idx_r <= '0;
      pend_pc_r  <= 32'd0;
      cnt_r      <= 4'd0;
    end else begin
      state_r    <= state_s;
      pend_idx_r <= pend_idx_s;
      pend_pc_r  <= pend_pc_s;
      cnt_r      <= cnt_s;
    end
  end

  // Output registers decoded from the next state, so each output lines up
  // with the state it belongs to while having no input-to-output path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
      dispatch_stall <= 1'b0;
      busy           <= 1'b0;
    end else begin
      flush          <= (state_s == ST_FLUSH);
      redirect_valid <= (state_s == ST_FLUSH);
      redirect_pc    <= (state_s == ST_FLUSH) ? pend_pc_r : 32'd0;
      dispatch_stall <= (state_s == ST_FLUSH) || (state_s == ST_RECOVER);
      busy           <= (state_s != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_br_flush_ctrl.sv
// -----------------------------------------------------------------------------
// tb_br_flush_ctrl
//   Directed self-checking bench for br_flush_ctrl (default parameters).
//   Inputs change just after the falling edge. Outputs are checked at the next
//   falling edge, i.e. after the rising edge that consumed those inputs.
// -----------------------------------------------------------------------------
module tb_br_flush_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        br_valid;
  logic        br_en;
  logic [3:0]  br_rob_idx;
  logic [31:0] br_pc_new;
  logic [3:0]  rob_head_idx;
  logic        rob_commit;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dispatch_stall;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  br_flush_ctrl #(
    .ROB_DEPTH(16),
    .ROB_IDX_W(4),
    .RECOVER_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .br_valid(br_valid),
    .br_en(br_en),
    .br_rob_idx(br_rob_idx),
    .br_pc_new(br_pc_new),
    .rob_head_idx(rob_head_idx),
    .rob_commit(rob_commit),
    .flush(flush),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .dispatch_stall(dispatch_stall),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic f, input logic rv,
                         input logic [31:0] pc, input logic st, input logic b);
    chk1({tag, ".flush"}, flush, f);
    chk1({tag, ".redirect_valid"}, redirect_valid, rv);
    chk32({tag, ".redirect_pc"}, redirect_pc, pc);
    chk1({tag, ".dispatch_stall"}, dispatch_stall, st);
    chk1({tag, ".busy"}, busy, b);
  endtask

  task automatic mispredict(input logic [3:0] head, input logic [3:0] idx, input logic [31:0] pc);
    rob_head_idx = head;
    br_valid     = 1'b1;
    br_en        = 1'b1;
    br_rob_idx   = idx;
    br_pc_new    = pc;
  endtask

  task automatic clear_inputs();
    br_valid   = 1'b0;
    br_en      = 1'b0;
    rob_commit = 1'b0;
  endtask

  // After a checked flush cycle: two stall cycles, then idle.
  task automatic finish_recovery(input string tag);
    clear_inputs();
    tick(); chk_out({tag, ".rec1"}, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    tick(); chk_out({tag, ".rec2"}, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    tick(); chk_out({tag, ".idle"}, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    rst          = 1'b1;
    br_valid     = 1'b0;
    br_en        = 1'b0;
    br_rob_idx   = 4'd0;
    br_pc_new    = 32'h0;
    rob_head_idx = 4'd0;
    rob_commit   = 1'b0;

    // Reset state
    #3;
    chk_out("reset", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick(); tick();
    rst = 1'b0;

    // Basic mispredict: capture on the first edge after reset release
    mispredict(4'd3, 4'd5, 32'h6000_0040);
    tick(); chk_out("basic.pend0", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    clear_inputs();
    tick(); chk_out("basic.pend1", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    tick(); chk_out("basic.pend2", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    tick(); chk_out("basic.pend3", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    rob_commit = 1'b1; rob_head_idx = 4'd5;
    tick(); chk_out("basic.flush", 1'b1, 1'b1, 32'h6000_0040, 1'b1, 1'b1);
    finish_recovery("basic");

    // IDLE ignores a same-cycle commit of the branch being captured
    mispredict(4'd5, 4'd5, 32'h0000_1234);
    rob_commit = 1'b1;
    tick(); chk_out("nocommit.pend", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    br_valid = 1'b0;
    tick(); chk_out("nocommit.flush", 1'b1, 1'b1, 32'h0000_1234, 1'b1, 1'b1);
    finish_recovery("nocommit");

    // Older replace with wrap-around: head=14, idx 15 is older than idx 1
    mispredict(4'd14, 4'd1, 32'h0000_0100);
    tick();
    mispredict(4'd14, 4'd15, 32'h0000_0200);
    tick(); chk_out("wrap.pend", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    clear_inputs();
    rob_commit = 1'b1; rob_head_idx = 4'd15;
    tick(); chk_out("wrap.flush", 1'b1, 1'b1, 32'h0000_0200, 1'b1, 1'b1);
    finish_recovery("wrap");

    // Younger mispredict ignored
    mispredict(4'd0, 4'd2, 32'h0000_0100);
    tick();
    mispredict(4'd0, 4'd7, 32'h0000_0300);
    tick(); chk_out("young.pend", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    clear_inputs();
    rob_commit = 1'b1; rob_head_idx = 4'd2;
    tick(); chk_out("young.flush", 1'b1, 1'b1, 32'h0000_0100, 1'b1, 1'b1);
    finish_recovery("young");

    // Not-taken result in IDLE: no state change
    rob_head_idx = 4'd3; br_valid = 1'b1; br_en = 1'b0;
    br_rob_idx = 4'd3; br_pc_new = 32'h0000_0999;
    tick(); chk_out("nottaken", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    clear_inputs();

    // Wrong-path branch and commit activity during FLUSH/RECOVER is dropped
    mispredict(4'd6, 4'd6, 32'h0000_0400);
    tick();
    clear_inputs();
    rob_commit = 1'b1;
    tick(); chk_out("wrong.flush", 1'b1, 1'b1, 32'h0000_0400, 1'b1, 1'b1);
    mispredict(4'd1, 4'd1, 32'h0000_0500);
    rob_commit = 1'b1;
    tick(); chk_out("wrong.rec1", 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    tick(); chk_out("wrong.rec2", 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    tick(); chk_out("wrong.idle", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    clear_inputs();
    tick(); chk_out("wrong.idle2", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Simultaneous commit and equal-index mispredict: one pulse, original pc
    mispredict(4'd0, 4'd4, 32'h0000_0700);
    tick();
    mispredict(4'd4, 4'd4, 32'h0000_0800);
    rob_commit = 1'b1;
    tick(); chk_out("simul.flush", 1'b1, 1'b1, 32'h0000_0700, 1'b1, 1'b1);
    finish_recovery("simul");

    // Async reset mid-RECOVER, between clock edges
    mispredict(4'd9, 4'd9, 32'h0000_0900);
    tick();
    clear_inputs();
    rob_commit = 1'b1;
    tick(); chk_out("arst.flush", 1'b1, 1'b1, 32'h0000_0900, 1'b1, 1'b1);
    clear_inputs();
    tick(); chk_out("arst.rec1", 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    #2 rst = 1'b1;
    #1 chk_out("arst.during", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    tick(); chk_out("arst.after1", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick(); chk_out("arst.after2", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Async reset mid-PENDING abandons the captured branch
    mispredict(4'd2, 4'd8, 32'h0000_0A00);
    tick(); chk1("prst.pend.busy", busy, 1'b1);
    clear_inputs();
    #2 rst = 1'b1;
    #1 chk_out("prst.during", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    rob_commit = 1'b1; rob_head_idx = 4'd8;
    tick(); chk_out("prst.after1", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick(); chk_out("prst.after2", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    clear_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
